weight_load_ctrl: RTL

//  Sequences the loading of one convolution tile of weights into the X*Y weight banks.

---
 rtl/weight_load_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/weight_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : weight_load_ctrl
//  Purpose  : Sequences one weight tile from a valid/ready stream into X*Y
//             weight banks, bank-major, with a clean pulse before each load.
//  Revision : 1.0
// ============================================================================
module weight_load_ctrl #(
    parameter int DW = 32,
    parameter int Tn = 16,
    parameter int Tm = 16,
    parameter int K  = 3,
    parameter int X  = 4,
    parameter int Y  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    wr_data,
    output logic [X*Y-1:0]   wr_ena,
    output logic             conv_tile_clean,
    output logic             busy,
    output logic             done
);

    localparam int c_NB       = X * Y;
    localparam int c_BANK_CAP = (Tn / Y) * (Tm / X) * K * K;
    localparam int c_WC_W     = (c_BANK_CAP > 1) ? $clog2(c_BANK_CAP) : 1;
    localparam int c_BC_W     = (c_NB > 1) ? $clog2(c_NB) : 1;

    localparam logic [c_WC_W-1:0] c_WORD_LAST = c_WC_W'(c_BANK_CAP - 1);
    localparam logic [c_BC_W-1:0] c_BANK_LAST = c_BC_W'(c_NB - 1);
    localparam logic [c_NB-1:0]   c_ENA_ONE   = c_NB'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CLEAN = 2'd1;
    localparam logic [1:0] c_LOAD  = 2'd2;
    localparam logic [1:0] c_FIN   = 2'd3;

    logic [1:0]        r_state;
    logic [c_WC_W-1:0] r_word_cnt;
    logic [c_BC_W-1:0] r_bank_cnt;
    logic              w_accept;
    logic              w_word_last;
    logic              w_tile_last;

    // Handshake and status are pure state decodes: no input-to-output paths.
    assign in_ready        = (r_state == c_LOAD);
    assign conv_tile_clean = (r_state == c_CLEAN);
    assign done            = (r_state == c_FIN);
    assign busy            = (r_state != c_IDLE);

    assign w_accept    = in_valid & in_ready;
    assign w_word_last = (r_word_cnt == c_WORD_LAST);
    assign w_tile_last = w_word_last && (r_bank_cnt == c_BANK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_word_cnt <= '0;
            r_bank_cnt <= '0;
            wr_data    <= '0;
            wr_ena     <= '0;
        end else begin
            wr_ena <= '0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_CLEAN;
                    end
                end
                c_CLEAN: begin
                    r_state    <= c_LOAD;
                    r_word_cnt <= '0;
                    r_bank_cnt <= '0;
                end
                c_LOAD: begin
                    if (w_accept) begin
                        wr_data <= in_data;
                        wr_ena  <= c_ENA_ONE << r_bank_cnt;
                        if (w_tile_last) begin
                            // Counters return to zero so no value past the last bank is held.
                            r_word_cnt <= '0;
                            r_bank_cnt <= '0;
                            r_state    <= c_FIN;
                        end else if (w_word_last) begin
                            r_word_cnt <= '0;
                            r_bank_cnt <= r_bank_cnt + c_BC_W'(1);
                        end else begin
                            r_word_cnt <= r_word_cnt + c_WC_W'(1);
                        end
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
